// File: rtl/sd_spi_responder.sv
// Card-side SPI-mode SD command responder.
// Parses 6-byte command frames from a byte-level SPI slave shifter and checks
// their CRC7. Good frames go to the card application logic. The block then
// plays back the Ncr filler, the R1 byte and an optional 4-byte R3/R7 payload
// on the outgoing byte stream.
module sd_spi_responder #(
   parameter int NCR_BYTES = 1,
   parameter int CHECK_CRC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic [7:0]  tx_byte,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   input  logic [7:0]  resp_r1,
   input  logic        resp_long,
   input  logic [31:0] resp_ext,
   output logic        crc_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      HUNT,
      CMD,
      CHECK,
      NCR,
      RESP
   } state_t;

   localparam logic [2:0] NCR_INIT = 3'(NCR_BYTES - 1);

   state_t      state, state_n;
   logic [2:0]  idx, idx_n;
   logic [6:0]  crc, crc_n;
   logic [5:0]  frame_cmd, frame_cmd_n;
   logic [31:0] frame_arg, frame_arg_n;
   logic [2:0]  cnt, cnt_n;
   logic [7:0]  rsp_r1, rsp_r1_n;
   logic        rsp_long, rsp_long_n;
   logic [31:0] rsp_ext, rsp_ext_n;
   logic [7:0]  tx_n;
   logic        valid_n, err_n;
   logic [5:0]  index_n;
   logic [31:0] arg_n;
   logic        crc_ok;

   // CRC7 (x^7 + x^3 + 1) folded over one byte, MSB first
   function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
      logic [6:0] r;
      logic [7:0] dd;
      logic       fb;
      r  = c;
      dd = d;
      for (int unsigned i = 0; i < 8; i++) begin
         fb = r[6] ^ dd[7];
         r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
         dd = {dd[6:0], 1'b0};
      end
      return r;
   endfunction

   assign busy   = (state != HUNT);
   assign crc_ok = (CHECK_CRC == 0) || (rx_byte[7:1] == crc);

   // next-state, frame capture and response sequencing
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      crc_n       = crc;
      frame_cmd_n = frame_cmd;
      frame_arg_n = frame_arg;
      cnt_n       = cnt;
      rsp_r1_n    = rsp_r1;
      rsp_long_n  = rsp_long;
      rsp_ext_n   = rsp_ext;
      tx_n        = tx_byte;
      valid_n     = 1'b0;
      err_n       = 1'b0;
      index_n     = cmd_index;
      arg_n       = cmd_arg;

      if (cs_n) begin
         state_n = HUNT;
         tx_n    = 8'hFF;
         cnt_n   = '0;
      end else begin
         unique case (state)
            HUNT: begin
               if (rx_valid && (rx_byte[7:6] == 2'b01)) begin
                  frame_cmd_n = rx_byte[5:0];
                  crc_n       = crc7_byte(7'h00, rx_byte);
                  idx_n       = 3'd1;
                  state_n     = CMD;
               end
            end
            CMD: begin
               if (rx_valid) begin
                  if (idx == 3'd5) begin
                     // Compare on the CRC byte's arrival, so that cmd_valid,
                     // cmd_index and cmd_arg are all registered into the CHECK cycle together.
                     state_n = CHECK;
                     tx_n    = 8'hFF;
                     if (crc_ok) begin
                        valid_n = 1'b1;
                        index_n = frame_cmd;
                        arg_n   = frame_arg;
                     end else begin
                        err_n = 1'b1;
                     end
                  end else begin
                     frame_arg_n = {frame_arg[23:0], rx_byte};
                     crc_n       = crc7_byte(crc, rx_byte);
                     idx_n       = idx + 3'd1;
                  end
               end
            end
            CHECK: begin
               if (cmd_valid) begin
                  rsp_r1_n   = resp_r1;
                  rsp_long_n = resp_long;
                  rsp_ext_n  = resp_ext;
               end else begin
                  rsp_r1_n   = 8'h08;
                  rsp_long_n = 1'b0;
               end
               tx_n    = 8'hFF;
               cnt_n   = NCR_INIT;
               state_n = NCR;
            end
            NCR: begin
               if (rx_valid) begin
                  if (cnt == 3'd0) begin
                     tx_n    = rsp_r1;
                     cnt_n   = rsp_long ? 3'd4 : 3'd0;
                     state_n = RESP;
                  end else begin
                     cnt_n = cnt - 3'd1;
                  end
               end
            end
            RESP: begin
               if (rx_valid) begin
                  if (cnt == 3'd0) begin
                     tx_n    = 8'hFF;
                     state_n = HUNT;
                  end else begin
                     case (cnt)
                        3'd4:    tx_n = rsp_ext[31:24];
                        3'd3:    tx_n = rsp_ext[23:16];
                        3'd2:    tx_n = rsp_ext[15:8];
                        default: tx_n = rsp_ext[7:0];
                     endcase
                     cnt_n = cnt - 3'd1;
                  end
               end
            end
            default: begin
               state_n = HUNT;
               tx_n    = 8'hFF;
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HUNT;
         idx       <= '0;
         crc       <= '0;
         frame_cmd <= '0;
         frame_arg <= '0;
         cnt       <= '0;
         rsp_r1    <= '0;
         rsp_long  <= 1'b0;
         rsp_ext   <= '0;
         tx_byte   <= '1;
         cmd_valid <= 1'b0;
         crc_err   <= 1'b0;
         cmd_index <= '0;
         cmd_arg   <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         crc       <= crc_n;
         frame_cmd <= frame_cmd_n;
         frame_arg <= frame_arg_n;
         cnt       <= cnt_n;
         rsp_r1    <= rsp_r1_n;
         rsp_long  <= rsp_long_n;
         rsp_ext   <= rsp_ext_n;
         tx_byte   <= tx_n;
         cmd_valid <= valid_n;
         crc_err   <= err_n;
         cmd_index <= index_n;
         cmd_arg   <= arg_n;
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: two instances (NCR_BYTES=1/CHECK_CRC=1 and
// NCR_BYTES=3/CHECK_CRC=0) share one host byte stream. A frame-level model
// predicts MISO bytes, pulses and held command fields.
module tb_sd_spi_responder;

   logic        clk = 1'b0;
   logic        rst, cs_n, rx_valid, resp_long;
   logic [7:0]  rx_byte, resp_r1;
   logic [31:0] resp_ext;

   logic [1:0][7:0]  tx;
   logic [1:0]       cv, ce, bz;
   logic [1:0][5:0]  ci;
   logic [1:0][31:0] ca;

   int total = 0;
   int bad   = 0;
   bit rand_resp = 1'b0;

   int          ncr_cfg [2] = '{1, 3};
   int          chk_cfg [2] = '{1, 0};
   logic [7:0]  mq   [2][16];
   int          qh   [2];
   int          qn   [2];
   logic [7:0]  fbuf [2][6];
   int          fn   [2];
   logic [5:0]  m_idx [2];
   logic [31:0] m_arg [2];

   always #5 clk = ~clk;

   sd_spi_responder #(.NCR_BYTES(1), .CHECK_CRC(1)) u0 (
      .clk(clk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_byte(tx[0]), .cmd_valid(cv[0]), .cmd_index(ci[0]), .cmd_arg(ca[0]),
      .resp_r1(resp_r1), .resp_long(resp_long), .resp_ext(resp_ext),
      .crc_err(ce[0]), .busy(bz[0])
   );

   sd_spi_responder #(.NCR_BYTES(3), .CHECK_CRC(0)) u1 (
      .clk(clk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_byte(tx[1]), .cmd_valid(cv[1]), .cmd_index(ci[1]), .cmd_arg(ca[1]),
      .resp_r1(resp_r1), .resp_long(resp_long), .resp_ext(resp_ext),
      .crc_err(ce[1]), .busy(bz[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // CRC7 as the remainder of polynomial long division by 0x89
   function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
      logic [46:0] r;
      r = {msg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   task automatic model_clear(input bit full);
      for (int d = 0; d < 2; d++) begin
         qh[d] = 0;
         qn[d] = 0;
         fn[d] = 0;
         if (full) begin
            m_idx[d] = '0;
            m_arg[d] = '0;
         end
      end
   endtask

   task automatic push(input int d, input logic [7:0] v);
      mq[d][qn[d]] = v;
      qn[d]++;
   endtask

   task automatic model_byte(input int d, input logic [7:0] b,
                             output logic [7:0] miso, output logic ev, output logic ee);
      logic [6:0] c;
      logic       ok;
      ev   = 1'b0;
      ee   = 1'b0;
      miso = 8'hFF;
      if (qn[d] > 0) begin
         miso = mq[d][qh[d]];
         qh[d]++;
         qn[d]--;
      end else if (fn[d] == 0) begin
         if (b[7:6] == 2'b01) begin
            fbuf[d][0] = b;
            fn[d] = 1;
         end
      end else begin
         fbuf[d][fn[d]] = b;
         fn[d]++;
         if (fn[d] == 6) begin
            fn[d] = 0;
            c  = ref_crc7({fbuf[d][0], fbuf[d][1], fbuf[d][2], fbuf[d][3], fbuf[d][4]});
            ok = (chk_cfg[d] == 0) || (fbuf[d][5][7:1] == c);
            qh[d] = 0;
            qn[d] = 0;
            for (int k = 0; k < ncr_cfg[d]; k++) push(d, 8'hFF);
            if (ok) begin
               ev       = 1'b1;
               m_idx[d] = fbuf[d][0][5:0];
               m_arg[d] = {fbuf[d][1], fbuf[d][2], fbuf[d][3], fbuf[d][4]};
               push(d, resp_r1);
               if (resp_long)
                  for (int k = 0; k < 4; k++) push(d, 8'(resp_ext >> (24 - 8 * k)));
            end else begin
               ee = 1'b1;
               push(d, 8'h08);
            end
         end
      end
   endtask

   // one byte exchange; entered and left on a negedge, 3 clk per exchange
   task automatic xchg(input logic [7:0] b);
      logic [7:0] m0, m1;
      logic       ev0, ee0, ev1, ee1;
      if (rand_resp) begin
         resp_r1   = 8'($urandom);
         resp_long = 1'($urandom);
         resp_ext  = $urandom;
      end
      model_byte(0, b, m0, ev0, ee0);
      model_byte(1, b, m1, ev1, ee1);
      check("miso0", tx[0], m0);
      check("miso1", tx[1], m1);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      check("cmd_valid0", cv[0], ev0);
      check("crc_err0",   ce[0], ee0);
      check("cmd_valid1", cv[1], ev1);
      check("crc_err1",   ce[1], ee1);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("busy%0d", d),      bz[d], (qn[d] > 0) || (fn[d] > 0));
         check($sformatf("cmd_index%0d", d), ci[d], m_idx[d]);
         check($sformatf("cmd_arg%0d", d),   ca[d], m_arg[d]);
      end
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("pulse_len_valid%0d", d), cv[d], 1'b0);
         check($sformatf("pulse_len_err%0d", d),   ce[d], 1'b0);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send6(input logic [47:0] f);
      for (int k = 5; k >= 0; k--) xchg(8'(f >> (8 * k)));
   endtask

   task automatic flush();
      repeat (10) xchg(8'hFF);
   endtask

   task automatic abort_frame();
      cs_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("abort_tx%0d", d),    tx[d], 8'hFF);
         check($sformatf("abort_busy%0d", d),  bz[d], 1'b0);
         check($sformatf("abort_valid%0d", d), cv[d], 1'b0);
         check($sformatf("abort_err%0d", d),   ce[d], 1'b0);
      end
      cs_n = 1'b0;
      model_clear(1'b0);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  b, crcb;
      logic [5:0]  ri;
      logic [31:0] ra;
      int          ab;

      rst = 1'b1; cs_n = 1'b0; rx_valid = 1'b0; rx_byte = '0;
      resp_r1 = 8'h01; resp_long = 1'b0; resp_ext = '0;
      model_clear(1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_tx%0d", d),    tx[d], 8'hFF);
         check($sformatf("rst_valid%0d", d), cv[d], 1'b0);
         check($sformatf("rst_err%0d", d),   ce[d], 1'b0);
         check($sformatf("rst_index%0d", d), ci[d], 6'd0);
         check($sformatf("rst_arg%0d", d),   ca[d], 32'd0);
         check($sformatf("rst_busy%0d", d),  bz[d], 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);

      // CMD0, short response
      send6(48'h40_00_00_00_00_95);
      flush();
      // CMD8 with R7 payload
      resp_long = 1'b1; resp_ext = 32'h0000_01AA;
      send6(48'h48_00_00_01_AA_87);
      flush();
      // CMD0 with a bad CRC byte
      resp_long = 1'b0;
      send6(48'h40_00_00_00_00_97);
      flush();
      // leading noise before a frame
      xchg(8'hFF); xchg(8'hFF); xchg(8'h3F);
      send6(48'h40_00_00_00_00_95);
      flush();
      // chip-select abort mid-frame, then a full frame
      xchg(8'h40); xchg(8'h00); xchg(8'h00);
      abort_frame();
      send6(48'h40_00_00_00_00_95);
      flush();
      // reset while the first instance is in its response phase
      resp_long = 1'b1; resp_ext = 32'h1234_5678;
      send6(48'h48_00_00_01_AA_87);
      xchg(8'hFF); xchg(8'hFF);
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("midrst_tx%0d", d),   tx[d], 8'hFF);
         check($sformatf("midrst_busy%0d", d), bz[d], 1'b0);
      end
      model_clear(1'b1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      resp_long = 1'b0; resp_r1 = 8'h01;
      send6(48'h40_00_00_00_00_95);
      flush();

      // randomized frames with noise, corrupted CRCs and aborts
      rand_resp = 1'b1;
      for (int n = 0; n < 40; n++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            b = 8'($urandom);
            if (b[7:6] == 2'b01) b[7] = 1'b1;
            xchg(b);
         end
         ri   = 6'($urandom);
         ra   = $urandom;
         crcb = {ref_crc7({2'b01, ri, ra}), 1'($urandom)};
         if ($urandom_range(0, 3) == 0) crcb = crcb ^ 8'(1 << $urandom_range(1, 7));
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 6;
         for (int k = 0; k < 6; k++) begin
            if (k == ab) break;
            case (k)
               0:       xchg({2'b01, ri});
               5:       xchg(crcb);
               default: xchg(8'(ra >> (8 * (4 - k))));
            endcase
         end
         if (ab < 6) abort_frame();
         xchg(8'($urandom));
         xchg(8'($urandom));
         repeat (8) xchg(8'hFF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: bench did not finish within the time limit");
      $fatal(1);
   end

endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

Card-side SPI-mode SD command responder: the counterpart of the host command controller. It sits behind a byte-level SPI slave shifter and parses 6-byte command frames from received bytes. It checks CRC7, hands the decoded command to the card application logic, and then drives the Ncr filler, the R1 byte and an optional 4-byte R3/R7 payload onto the outgoing byte stream. It is used as the SD card model in host-controller verification and as the front end of an SPI-attached storage target.

## Interface
Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes between the command's last byte and R1; legal range 1..8.
- CHECK_CRC, 1, 1 = reject frames whose CRC7 mismatches; 0 = accept any CRC.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cs_n  in  1  SPI chip select, active low; high forces frame abort.
- rx_valid  in  1  one-cycle pulse per completed byte exchange; pulses are at least 3 clk apart.
- rx_byte  in  8  byte received from host (MOSI), valid with rx_valid.
- tx_byte  out  8  byte the shifter sends in the next exchange (MISO); registered.
- cmd_valid  out  1  one-cycle pulse: a good command frame was received.
- cmd_index  out  6  command index (frame byte0[5:0]), held until next frame.
- cmd_arg  out  32  argument, bytes 1..4, MSB first; held.
- resp_r1  in  8  R1 value; sampled in the cmd_valid cycle.
- resp_long  in  1  1 = append 4 payload bytes (R3/R7); sampled with resp_r1.
- resp_ext  in  32  payload, sent MSB byte first; sampled with resp_r1.
- crc_err  out  1  one-cycle pulse: frame CRC7 mismatched (CHECK_CRC=1 only).
- busy  out  1  high whenever state != HUNT.

## Operation
- States: HUNT, CMD, CHECK, NCR, RESP.
- HUNT: tx_byte=0xFF. On rx_valid with rx_byte[7:6]==2'b01: store the byte as byte0, clear the CRC, fold the byte into the CRC, set idx=1, go to CMD. Other bytes are ignored.
- CMD: each rx_valid stores rx_byte at idx.
  - Bytes 1..4 are folded into CRC7 (polynomial x^7+x^3+1, init 0, MSB first, computed one byte per rx_valid).
  - On idx==5, go to CHECK. The end bit (byte5[0]) is not checked.
- CHECK (exactly 1 cycle): compare byte5[7:1] to the CRC.
  - Match or CHECK_CRC=0: pulse cmd_valid, update cmd_index/cmd_arg, latch resp_r1/resp_long/resp_ext.
  - Mismatch: pulse crc_err, latch R1=0x08 (COM CRC error) and resp_long=0; cmd_index/cmd_arg are unchanged.
  - In both cases: tx_byte=0xFF, cnt=NCR_BYTES-1, go to NCR.
- NCR: on rx_valid, if cnt==0 then tx_byte=latched R1, cnt = resp_long ? 4 : 0, go to RESP; else cnt--.
- RESP: on rx_valid, if cnt==0 then tx_byte=0xFF, go to HUNT; else tx_byte=ext[8*cnt-1 -: 8], cnt--.
- Received bytes during NCR/RESP are ignored; a command start byte there does not start a new frame.
- cs_n high in any cycle: go to HUNT, tx_byte=0xFF, cnt=0, no pulses. It overrides a simultaneous rx_valid.
- Reset: state HUNT, tx_byte=0xFF, cmd_valid=0, crc_err=0, cmd_index=0, cmd_arg=0, busy=0, latched response cleared. Reset mid-frame discards the frame with no pulse.

## Timing
- tx_byte changes only in the cycle after rx_valid, on entry to CHECK/NCR, or on cs_n/reset; it is stable for ≥2 cycles before the next exchange.
- The CHECK cycle falls 1 clk after the 6th rx_valid. cmd_valid/crc_err are high for exactly that one cycle, 1 clk after the final rx_valid.
- Byte stream after the last command byte: NCR_BYTES × 0xFF, then R1, then 0 or 4 payload bytes, then 0xFF (state HUNT).
- The next frame is accepted on the first rx_valid after the return to HUNT.
- busy rises the cycle after byte0's rx_valid and falls the cycle after the final response byte's rx_valid is consumed.

## Test plan
- CMD0 (40 00 00 00 00 95), resp_r1=0x01, resp_long=0, NCR_BYTES=1:
  - cmd_valid pulses once with cmd_index=0, cmd_arg=0.
  - Following MISO bytes: FF, 01, FF.
- CMD8 (48 00 00 01 AA 87), resp_r1=0x01, resp_long=1, resp_ext=0x000001AA:
  - cmd_index=8, cmd_arg=0x000001AA.
  - MISO: FF, 01, 00, 00, 01, AA, FF.
- CMD0 with CRC byte 0x97, CHECK_CRC=1:
  - crc_err pulses, no cmd_valid, MISO FF, 08, FF.
  - Same frame with CHECK_CRC=0 gives cmd_valid.
- Leading FF, FF, 3F bytes before a CMD0: all ignored, the frame is still decoded. NCR_BYTES=3 gives MISO FF, FF, FF, 01.
- cs_n raised after byte 3 of a frame, then a full CMD0: no pulse for the aborted frame, the second frame decodes normally, tx_byte=0xFF during the abort.
- rst asserted during RESP: tx_byte=0xFF and busy=0 immediately; the next CMD0 is decoded correctly.
